// File: rtl/bus_trace_fifo.sv
// Bus trace FIFO: captures completed data-bus writes and reads from the core's
// debug bus and presents them on a valid/ready drain port for a serializer.
module bus_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [31:0]              dbg_waddr,
    input  logic [31:0]              dbg_wdata,
    input  logic [3:0]               dbg_wstrb,
    input  logic                     dbg_wen,
    input  logic                     dbg_wready,
    input  logic [31:0]              dbg_raddr,
    input  logic                     dbg_ren,
    input  logic                     dbg_rvalid,
    input  logic [31:0]              dbg_rdata,
    input  logic [31:0]              dbg_cycle,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_is_read,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [3:0]               out_strb,
    output logic [31:0]              out_time,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic        isRead;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] stamp;
    } traceEntry_t;

    traceEntry_t      mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] wrPtrPlus1;
    logic [31:0]      pendAddr;

    traceEntry_t      wrEntry;
    traceEntry_t      rdEntry;
    traceEntry_t      slot0;
    traceEntry_t      head;
    logic             writeEv;
    logic             readEv;
    logic             popEn;
    logic             storeW;
    logic             storeR;
    logic [OCC_W-1:0] freeSlots;
    logic [1:0]       pushN;
    logic [1:0]       dropN;
    logic [SUM_W-1:0] dropSum;
    logic [CNT_W-1:0] dropSat;

    // Slot allocation: the write entry always claims the lower slot when both events land together.
    always_comb begin
        writeEv    = enable & dbg_wen & dbg_wready;
        readEv     = enable & dbg_rvalid;
        popEn      = out_valid & out_ready;
        freeSlots  = OCC_W'(DEPTH) - (count - OCC_W'(popEn));
        wrEntry    = {1'b0, dbg_waddr, dbg_wdata, dbg_wstrb, dbg_cycle};
        rdEntry    = {1'b1, pendAddr, dbg_rdata, 4'hF, dbg_cycle};
        storeW     = 1'b0;
        storeR     = 1'b0;
        if (writeEv && readEv) begin
            storeW = (freeSlots != '0);
            storeR = (freeSlots >= OCC_W'(2));
        end else begin
            storeW = writeEv && (freeSlots != '0);
            storeR = readEv && (freeSlots != '0);
        end
        pushN      = 2'(storeW) + 2'(storeR);
        dropN      = 2'(writeEv & ~storeW) + 2'(readEv & ~storeR);
        slot0      = storeW ? wrEntry : rdEntry;
        wrPtrPlus1 = PTR_W'(wrPtr + 1'b1);
        dropSum    = {1'b0, drop_count} + SUM_W'(dropN);
        dropSat    = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
    end

    // Pointer, occupancy and drop bookkeeping
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            pendAddr   <= '0;
        end else begin
            if (dbg_ren) begin
                pendAddr <= dbg_raddr;
            end
            if (clear) begin
                rdPtr      <= '0;
                wrPtr      <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                drop_count <= '0;
            end else begin
                if (popEn) begin
                    rdPtr <= PTR_W'(rdPtr + 1'b1);
                end
                wrPtr      <= PTR_W'(wrPtr + PTR_W'(pushN));
                count      <= count - OCC_W'(popEn) + OCC_W'(pushN);
                drop_count <= dropSat;
                if (dropN != 2'd0) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Entry storage; never written at an occupied slot, so the head stays stable
    always_ff @(posedge clock) begin
        if (!clear) begin
            if (pushN != 2'd0) begin
                mem[wrPtr] <= slot0;
            end
            if (pushN == 2'd2) begin
                mem[wrPtrPlus1] <= rdEntry;
            end
        end
    end

    // Drain port driven from the head entry, zeroed while empty
    always_comb begin
        head        = mem[rdPtr];
        out_valid   = (count != '0);
        out_is_read = 1'b0;
        out_addr    = '0;
        out_data    = '0;
        out_strb    = '0;
        out_time    = '0;
        if (out_valid) begin
            out_is_read = head.isRead;
            out_addr    = head.addr;
            out_data    = head.data;
            out_strb    = head.strb;
            out_time    = head.stamp;
        end
    end

endmodule
